// File: rtl/path_tracer.sv
// Walks the converged path_dir field from a destination cell back to the cost-0
// source, streaming one cell per valid/ready beat and flagging broken chains.
module path_tracer #(
  parameter int XW        = 5,
  parameter int YW        = 5,
  parameter int MAX_STEPS = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [XW-1:0] dst_x,
  input  logic [YW-1:0] dst_y,
  output logic [XW-1:0] rd_x,
  output logic [YW-1:0] rd_y,
  input  logic [11:0]   rd_cost,
  input  logic [2:0]    rd_dir,
  output logic          step_valid,
  input  logic          step_ready,
  output logic [XW-1:0] step_x,
  output logic [YW-1:0] step_y,
  output logic [2:0]    step_dir,
  output logic [11:0]   step_cost,
  output logic          step_last,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int CW = $clog2(MAX_STEPS + 1);
  localparam logic [XW:0] X1 = (XW+1)'(1);
  localparam logic [YW:0] Y1 = (YW+1)'(1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_CHK, S_EMIT, S_FIN} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic          err_flag;
  logic [XW:0]   nb_x;
  logic [YW:0]   nb_y;
  logic          x_inc, x_dec, y_inc, y_dec;
  logic          off_grid, cnt_hit, hs, unreach;

  // Direction decode: N=0 clockwise to NW=7, y grows southwards.
  always_comb begin
    x_inc = (step_dir == 3'd1) || (step_dir == 3'd2) || (step_dir == 3'd3);
    x_dec = (step_dir == 3'd5) || (step_dir == 3'd6) || (step_dir == 3'd7);
    y_inc = (step_dir == 3'd3) || (step_dir == 3'd4) || (step_dir == 3'd5);
    y_dec = (step_dir == 3'd7) || (step_dir == 3'd0) || (step_dir == 3'd1);
    nb_x  = {1'b0, rd_x};
    nb_y  = {1'b0, rd_y};
    if (x_inc) nb_x = nb_x + X1;
    if (x_dec) nb_x = nb_x - X1;
    if (y_inc) nb_y = nb_y + Y1;
    if (y_dec) nb_y = nb_y - Y1;
  end

  // Extra top bit catches both 0-1 borrow and max+1 carry.
  assign off_grid = nb_x[XW] | nb_y[YW];
  assign cnt_hit  = (cnt == CW'(MAX_STEPS - 1));
  assign hs       = (state == S_EMIT) && step_ready;
  assign unreach  = (rd_cost == 12'hFFF);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start) state_nx = S_REQ;
      S_REQ:  state_nx = S_CHK;
      S_CHK:  state_nx = unreach ? S_FIN : S_EMIT;
      S_EMIT: if (step_ready) state_nx = (step_last || cnt_hit || off_grid) ? S_FIN : S_REQ;
      S_FIN:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      err_flag  <= 1'b0;
      rd_x      <= '0;
      rd_y      <= '0;
      step_x    <= '0;
      step_y    <= '0;
      step_dir  <= '0;
      step_cost <= '0;
      step_last <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: if (start) begin
          rd_x     <= dst_x;
          rd_y     <= dst_y;
          cnt      <= '0;
          err_flag <= 1'b0;
        end
        S_CHK: begin
          step_x    <= rd_x;
          step_y    <= rd_y;
          step_cost <= rd_cost;
          step_dir  <= rd_dir;
          step_last <= (rd_cost == 12'd0);
          if (unreach) err_flag <= 1'b1;
        end
        S_EMIT: if (hs && !step_last) begin
          if (cnt_hit || off_grid) begin
            err_flag <= 1'b1;
          end else begin
            rd_x <= nb_x[XW-1:0];
            rd_y <= nb_y[YW-1:0];
            cnt  <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign step_valid = (state == S_EMIT);
  assign busy       = (state == S_REQ) || (state == S_CHK) || (state == S_EMIT);
  assign done       = (state == S_FIN) && !err_flag;
  assign err        = (state == S_FIN) && err_flag;

endmodule
